// File: rtl/usb_tx_pkg.sv
// usb_tx_pkg: shared FSM states, shifter load selects, PID bytes and hs_type encoding for the USB TX sequencer
package usb_tx_pkg;
  typedef enum logic [2:0] {
    ST_IDLE, ST_SYNC, ST_PID, ST_DATA, ST_CRC1, ST_CRC2, ST_EOP, ST_DONE
  } state_t;
  typedef enum logic [2:0] {
    SEL_SYNC = 3'd0, SEL_PID = 3'd1, SEL_DATA = 3'd2, SEL_CRC1 = 3'd3, SEL_CRC2 = 3'd4
  } load_sel_t;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;
  localparam logic [7:0] PID_STALL = 8'h1E;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam logic [1:0] HS_ACK = 2'd0;
  localparam logic [1:0] HS_NAK = 2'd1;
  function automatic logic [7:0] hs_pid(input logic [1:0] t);
    return t == HS_ACK ? PID_ACK : t == HS_NAK ? PID_NAK : PID_STALL;
  endfunction
endpackage

// File: rtl/usb_tx_bitcnt.sv
// usb_tx_bitcnt: field bit counter and remaining payload byte counter with last-bit/last-byte flags
// Ports: clk, rst (async, active high); bit_clr/bit_inc drive bit_cnt; rem_ld/rem_val/rem_dec drive
// the remaining-byte count; last_bit = 8th bit of a field is current, last_byte = no payload bytes left.
module usb_tx_bitcnt #(
  parameter int BIT_W = 3,
  parameter int LEN_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_clr,
  input  logic             bit_inc,
  input  logic             rem_ld,
  input  logic [LEN_W-1:0] rem_val,
  input  logic             rem_dec,
  output logic [BIT_W-1:0] bit_cnt,
  output logic             last_bit,
  output logic             last_byte
);
  logic [LEN_W-1:0] rem;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bit_cnt <= '0;
      rem <= '0;
    end else begin
      bit_cnt <= bit_clr ? '0 : bit_inc ? bit_cnt + 1'b1 : bit_cnt;
      rem <= rem_ld ? rem_val : rem_dec ? rem - 1'b1 : rem;
    end
  assign last_bit = bit_cnt == BIT_W'(7);
  assign last_byte = rem == '0;
endmodule

// File: rtl/usb_tx_pkt_ctrl.sv
// usb_tx_pkt_ctrl: USB packet transmit sequencer (SYNC/PID/payload/CRC16/EOP and handshakes)
// Ports: bit_stb paces every field; tx_start/tx_ep/tx_len/tx_pid1 request a data packet, hs_req/hs_type a
// handshake; ack_rcvd/ack_ep flip an endpoint toggle; fifo_empty/fifo_pop talk to the show-ahead TX FIFO;
// load/load_sel/pid_byte/shift_en drive the serializer and CRC mux; eop, busy, tx_done, underrun report status.
// Build option: define USB_TX_TOGGLE_EN for per-endpoint DATA0/DATA1 toggles instead of tx_pid1.
module usb_tx_pkt_ctrl
  import usb_tx_pkg::*;
#(
  parameter int MAX_PAYLOAD = 64,
  parameter int NUM_EP = 4,
  parameter int EOP_BITS = 3,
  localparam int LEN_W = $clog2(MAX_PAYLOAD + 1),
  localparam int EP_W = NUM_EP > 1 ? $clog2(NUM_EP) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_stb,
  input  logic             tx_start,
  input  logic [EP_W-1:0]  tx_ep,
  input  logic [LEN_W-1:0] tx_len,
  input  logic             tx_pid1,
  input  logic             hs_req,
  input  logic [1:0]       hs_type,
  input  logic             ack_rcvd,
  input  logic [EP_W-1:0]  ack_ep,
  input  logic             fifo_empty,
  output logic             fifo_pop,
  output logic             load,
  output logic [2:0]       load_sel,
  output logic [7:0]       pid_byte,
  output logic             shift_en,
  output logic             eop,
  output logic             busy,
  output logic             tx_done,
  output logic             underrun
);
  localparam int BIT_W = EOP_BITS > 8 ? $clog2(EOP_BITS) : 3;
  state_t state, nxt_state;
  load_sel_t sel_q, nxt_sel;
  logic nxt_load, nxt_pop, nxt_und;
  logic [7:0] nxt_pid, pid_val;
  logic is_data, data1, accept, stb_end, last_bit, last_byte, bit_clr, bit_inc, rem_dec;
  logic [1:0] hs_q;
  logic [BIT_W-1:0] bit_cnt;
  logic [LEN_W-1:0] len_clamped, rem_val;
  assign accept = state == ST_IDLE && (hs_req || tx_start);
  assign len_clamped = tx_len > LEN_W'(MAX_PAYLOAD) ? LEN_W'(MAX_PAYLOAD) : tx_len;
  assign rem_val = hs_req ? '0 : len_clamped;
  assign stb_end = bit_stb && last_bit;
  assign pid_val = is_data ? (data1 ? PID_DATA1 : PID_DATA0) : hs_pid(hs_q);
  // Any field change or new byte load restarts the bit count; a strobe in the load cycle is then bit 0.
  assign bit_clr = nxt_state != state || nxt_load;
  assign bit_inc = bit_stb && state != ST_IDLE && state != ST_DONE;
  assign rem_dec = nxt_load && nxt_sel == SEL_DATA;
  usb_tx_bitcnt #(.BIT_W(BIT_W), .LEN_W(LEN_W)) u_cnt (
    .clk(clk), .rst(rst), .bit_clr(bit_clr), .bit_inc(bit_inc), .rem_ld(accept), .rem_val(rem_val),
    .rem_dec(rem_dec), .bit_cnt(bit_cnt), .last_bit(last_bit), .last_byte(last_byte)
  );
  always_comb begin
    nxt_state = state;
    nxt_sel = sel_q;
    nxt_load = 1'b0;
    nxt_pop = 1'b0;
    nxt_und = 1'b0;
    nxt_pid = pid_byte;
    case (state)
      ST_IDLE: if (accept) begin
        nxt_state = ST_SYNC;
        nxt_sel = SEL_SYNC;
        nxt_load = 1'b1;
      end
      ST_SYNC: if (stb_end) begin
        nxt_state = ST_PID;
        nxt_sel = SEL_PID;
        nxt_load = 1'b1;
        nxt_pid = pid_val;
      end
      ST_PID, ST_DATA: if (stb_end) begin
        if (!is_data) nxt_state = ST_EOP;
        else if (last_byte) begin
          nxt_state = ST_CRC1;
          nxt_sel = SEL_CRC1;
          nxt_load = 1'b1;
        end else if (fifo_empty) begin
          // Starved payload: cut the packet short with an EOP instead of sending a stale byte.
          nxt_state = ST_EOP;
          nxt_und = 1'b1;
        end else begin
          nxt_state = ST_DATA;
          nxt_sel = SEL_DATA;
          nxt_load = 1'b1;
          nxt_pop = 1'b1;
        end
      end
      ST_CRC1: if (stb_end) begin
        nxt_state = ST_CRC2;
        nxt_sel = SEL_CRC2;
        nxt_load = 1'b1;
      end
      ST_CRC2: if (stb_end) nxt_state = ST_EOP;
      ST_EOP: if (bit_stb && bit_cnt == BIT_W'(EOP_BITS - 1)) nxt_state = ST_DONE;
      default: nxt_state = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ST_IDLE;
      sel_q <= SEL_SYNC;
      load <= 1'b0;
      fifo_pop <= 1'b0;
      underrun <= 1'b0;
      pid_byte <= '0;
      is_data <= 1'b0;
      hs_q <= '0;
    end else begin
      state <= nxt_state;
      sel_q <= nxt_sel;
      load <= nxt_load;
      fifo_pop <= nxt_pop;
      underrun <= nxt_und;
      pid_byte <= nxt_pid;
      if (accept) begin
        is_data <= !hs_req;
        hs_q <= hs_type;
      end
    end
`ifdef USB_TX_TOGGLE_EN
  logic [NUM_EP-1:0] tog;
  logic [EP_W-1:0] ep_q;
  logic unused;
  assign unused = &{1'b0, tx_pid1};
  assign data1 = tog[ep_q];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tog <= '0;
      ep_q <= '0;
    end else begin
      if (accept) ep_q <= tx_ep;
      if (ack_rcvd) tog[ack_ep] <= ~tog[ack_ep];
    end
`else
  logic pid1_q;
  logic unused;
  assign unused = &{1'b0, ack_rcvd, ack_ep, tx_ep};
  assign data1 = pid1_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) pid1_q <= 1'b0;
    else if (accept) pid1_q <= tx_pid1;
`endif
  assign load_sel = sel_q;
  assign shift_en = bit_stb && state inside {ST_SYNC, ST_PID, ST_DATA, ST_CRC1, ST_CRC2};
  assign eop = state == ST_EOP;
  assign busy = state != ST_IDLE;
  assign tx_done = state == ST_DONE;
endmodule

// File: tb/tb_usb_tx_pkt_ctrl.sv
// tb_usb_tx_pkt_ctrl: directed bench with a field-queue model checked every cycle against usb_tx_pkt_ctrl
module tb_usb_tx_pkt_ctrl;
  localparam int MAX_PAYLOAD = 64;
  localparam int NUM_EP = 4;
  localparam int EOP_BITS = 3;
  localparam int LEN_W = $clog2(MAX_PAYLOAD + 1);
  localparam int EP_W = NUM_EP > 1 ? $clog2(NUM_EP) : 1;
  logic clk = 1'b0, rst = 1'b1, bit_stb = 1'b0, tx_start = 1'b0, tx_pid1 = 1'b0, hs_req = 1'b0;
  logic ack_rcvd = 1'b0, fifo_empty;
  logic [EP_W-1:0] tx_ep = '0, ack_ep = '0;
  logic [LEN_W-1:0] tx_len = '0;
  logic [1:0] hs_type = '0;
  logic fifo_pop, load, shift_en, eop, busy, tx_done, underrun;
  logic [2:0] load_sel;
  logic [7:0] pid_byte;
  int n_vec = 0, n_err = 0, fifo_n = 0, stb_per = 1, sc = 0;
  bit pop_seen = 1'b0;
  // Model: queue of remaining fields (0 SYNC,1 PID,2 DATA,3 CRC1,4 CRC2,5 EOP,6 DONE), head is current.
  int fq[$];
  int m_cnt = 0;
  bit m_first = 1'b0, m_und = 1'b0;
  logic [7:0] m_pid = '0;
  bit [NUM_EP-1:0] m_tog = '0;
  int stb_cnt = 0, pops = 0, unds = 0, done_cnt = 0, p_stb = 0, p_pops = 0, p_und = 0;
  logic [7:0] last_pid = '0, p_pid = '0;
  assign fifo_empty = fifo_n == 0;
  usb_tx_pkt_ctrl #(.MAX_PAYLOAD(MAX_PAYLOAD), .NUM_EP(NUM_EP), .EOP_BITS(EOP_BITS)) dut (
    .clk(clk), .rst(rst), .bit_stb(bit_stb), .tx_start(tx_start), .tx_ep(tx_ep), .tx_len(tx_len),
    .tx_pid1(tx_pid1), .hs_req(hs_req), .hs_type(hs_type), .ack_rcvd(ack_rcvd), .ack_ep(ack_ep),
    .fifo_empty(fifo_empty), .fifo_pop(fifo_pop), .load(load), .load_sel(load_sel), .pid_byte(pid_byte),
    .shift_en(shift_en), .eop(eop), .busy(busy), .tx_done(tx_done), .underrun(underrun)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    fq.delete();
    m_cnt = 0;
    m_first = 1'b0;
    m_und = 1'b0;
    m_tog = '0;
    stb_cnt = 0;
    pops = 0;
    unds = 0;
  endtask
  task automatic advance();
    int n, need, c;
    if (rst) begin
      model_reset();
      return;
    end
    m_first = 1'b0;
    m_und = 1'b0;
`ifdef USB_TX_TOGGLE_EN
    if (ack_rcvd) m_tog[ack_ep] = ~m_tog[ack_ep];
`endif
    if (fq.size() == 0) begin
      if (hs_req) begin
        fq = '{0, 1, 5, 6};
        m_pid = hs_type == 2'd0 ? 8'hD2 : hs_type == 2'd1 ? 8'h5A : 8'h1E;
        m_first = 1'b1;
        m_cnt = 0;
      end else if (tx_start) begin
        n = int'(tx_len) > MAX_PAYLOAD ? MAX_PAYLOAD : int'(tx_len);
        fq = '{0, 1};
        repeat (n) fq.push_back(2);
        fq.push_back(3);
        fq.push_back(4);
        fq.push_back(5);
        fq.push_back(6);
`ifdef USB_TX_TOGGLE_EN
        m_pid = m_tog[tx_ep] ? 8'h4B : 8'hC3;
`else
        m_pid = tx_pid1 ? 8'h4B : 8'hC3;
`endif
        m_first = 1'b1;
        m_cnt = 0;
      end
    end else begin
      c = fq[0];
      if (c == 6) fq.pop_front();
      else if (bit_stb) begin
        m_cnt++;
        need = c == 5 ? EOP_BITS : 8;
        if (m_cnt == need) begin
          fq.pop_front();
          m_cnt = 0;
          m_first = 1'b1;
          if (fq[0] == 2 && fifo_empty) begin
            while (fq[0] != 5) fq.pop_front();
            m_und = 1'b1;
          end
        end
      end
    end
  endtask
  task automatic check();
    bit f, el;
    int c;
    if (rst) model_reset();
    f = fq.size() != 0;
    c = f ? fq[0] : -1;
    el = f && m_first && c <= 4;
    chk("busy", 32'(busy), 32'(f));
    chk("load", 32'(load), 32'(el));
    chk("fifo_pop", 32'(fifo_pop), 32'(el && c == 2));
    chk("eop", 32'(eop), 32'(c == 5));
    chk("tx_done", 32'(tx_done), 32'(c == 6));
    chk("shift_en", 32'(shift_en), 32'(bit_stb && f && c <= 4));
    chk("underrun", 32'(underrun), 32'(m_und));
    if (el) chk("load_sel", 32'(load_sel), 32'(c));
    if (el && c == 1) chk("pid_byte", 32'(pid_byte), 32'(m_pid));
    if (rst) begin
      chk("rst_pid_byte", 32'(pid_byte), 0);
      chk("rst_load_sel", 32'(load_sel), 0);
    end
    stb_cnt += int'(shift_en || (eop && bit_stb));
    pops += int'(fifo_pop);
    unds += int'(underrun);
    if (load && load_sel == 3'd1) last_pid = pid_byte;
    if (tx_done) begin
      p_stb = stb_cnt;
      p_pops = pops;
      p_und = unds;
      p_pid = last_pid;
      done_cnt++;
      stb_cnt = 0;
      pops = 0;
      unds = 0;
    end
  endtask
  initial forever begin
    @(negedge clk);
    check();
    @(posedge clk);
    advance();
  end
  initial forever begin
    @(posedge clk);
    #1;
    sc++;
    bit_stb = (sc % stb_per) == 0;
  end
  initial forever begin
    @(negedge clk);
    pop_seen = fifo_pop;
    @(posedge clk);
    #1;
    if (pop_seen && fifo_n > 0) fifo_n--;
  end
  task automatic run_pkt(input bit hs, input bit ts, input logic [1:0] t, input int ep, input int len,
                         input bit p1, input int bytes);
    int d0;
    d0 = done_cnt;
    fifo_n = bytes;
    hs_req = hs;
    tx_start = ts;
    hs_type = t;
    tx_ep = EP_W'(ep);
    tx_len = LEN_W'(len);
    tx_pid1 = p1;
    for (int i = 0; i < 20 && !busy; i++) begin
      @(posedge clk);
      #1;
    end
    chk("accepted", 32'(busy), 1);
    hs_req = 1'b0;
    tx_start = 1'b0;
    for (int i = 0; i < 20000 && done_cnt == d0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("completed", 32'(done_cnt - d0), 1);
  endtask
  task automatic ack(input int ep);
    ack_rcvd = 1'b1;
    ack_ep = EP_W'(ep);
    @(posedge clk);
    #1;
    ack_rcvd = 1'b0;
  endtask
  initial begin
    int d0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 0);
    chk("reset_load", 32'(load), 0);
    chk("reset_eop", 32'(eop), 0);
    chk("reset_done", 32'(tx_done), 0);
    chk("reset_pid", 32'(pid_byte), 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    stb_per = 1;
    run_pkt(1'b1, 1'b0, 2'd0, 0, 0, 1'b0, 0);
    chk("ack_pid", 32'(p_pid), 32'hD2);
    chk("ack_strobes", p_stb, 19);
    stb_per = 3;
    run_pkt(1'b1, 1'b0, 2'd1, 0, 0, 1'b0, 0);
    chk("nak_pid", 32'(p_pid), 32'h5A);
    chk("nak_strobes", p_stb, 19);
    stb_per = 4;
    run_pkt(1'b0, 1'b1, 2'd0, 1, 3, 1'b0, 3);
    chk("data_pid", 32'(p_pid), 32'hC3);
    chk("data_pops", p_pops, 3);
    chk("data_strobes", p_stb, 59);
    chk("data_underrun", p_und, 0);
    stb_per = 3;
    run_pkt(1'b0, 1'b1, 2'd0, 2, 0, 1'b0, 5);
    chk("zlp_pops", p_pops, 0);
    chk("zlp_strobes", p_stb, 35);
    stb_per = 2;
    run_pkt(1'b0, 1'b1, 2'd0, 3, 4, 1'b0, 2);
    chk("und_pulses", p_und, 1);
    chk("und_pops", p_pops, 2);
    chk("und_strobes", p_stb, 35);
    stb_per = 1;
    run_pkt(1'b0, 1'b1, 2'd0, 0, 100, 1'b0, 64);
    chk("clamp_pops", p_pops, 64);
    chk("clamp_strobes", p_stb, 547);
`ifdef USB_TX_TOGGLE_EN
    ack(1);
    run_pkt(1'b0, 1'b1, 2'd0, 1, 1, 1'b0, 1);
    chk("tog_ep1_pid", 32'(p_pid), 32'h4B);
    run_pkt(1'b0, 1'b1, 2'd0, 0, 1, 1'b1, 1);
    chk("tog_ep0_pid", 32'(p_pid), 32'hC3);
`else
    run_pkt(1'b0, 1'b1, 2'd0, 1, 1, 1'b1, 1);
    chk("pid1_pid", 32'(p_pid), 32'h4B);
`endif
    stb_per = 2;
    run_pkt(1'b1, 1'b1, 2'd2, 0, 2, 1'b0, 2);
    chk("coll_pid", 32'(p_pid), 32'h1E);
    chk("coll_pops", p_pops, 0);
    chk("coll_strobes", p_stb, 19);
    repeat (10) @(posedge clk);
    #1;
    chk("coll_dropped", 32'(busy), 0);
`ifdef USB_TX_TOGGLE_EN
    ack(0);
`endif
    d0 = done_cnt;
    fifo_n = 3;
    tx_start = 1'b1;
    tx_ep = '0;
    tx_len = LEN_W'(3);
    tx_pid1 = 1'b1;
    for (int i = 0; i < 20 && !busy; i++) begin
      @(posedge clk);
      #1;
    end
    tx_start = 1'b0;
    for (int i = 0; i < 2000 && !(load && load_sel == 3'd2); i++) begin
      @(posedge clk);
      #1;
    end
    chk("abort_reached_data", 32'(load && load_sel == 3'd2), 1);
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_load", 32'(load), 0);
    chk("abort_sel", 32'(load_sel), 0);
    chk("abort_pop", 32'(fifo_pop), 0);
    chk("abort_pid", 32'(pid_byte), 0);
    chk("abort_shift", 32'(shift_en), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    fifo_n = 0;
    repeat (20) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_no_eop", 32'(eop), 0);
    run_pkt(1'b0, 1'b1, 2'd0, 0, 0, 1'b0, 0);
    chk("post_rst_pid", 32'(p_pid), 32'hC3);
    chk("post_rst_strobes", p_stb, 35);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/usb_tx_pkt_ctrl.md
# usb_tx_pkt_ctrl

Parametrised USB packet transmit controller: the second-generation transmit sequencer of the bridge's USB side. It sequences SYNC, PID, a variable-length payload from the TX FIFO, CRC16 and EOP for data packets, and SYNC, PID and EOP for ACK/NAK/STALL handshakes. It owns its own bit and byte counting, so no external count-done is needed, and keeps per-endpoint DATA0/DATA1 toggles. It drives the parallel-to-serial shifter (load/select/shift), the TX FIFO pop and the CRC mux.

## Interface
- MAX_PAYLOAD, 64: maximum payload bytes per data packet; LEN_W = $clog2(MAX_PAYLOAD+1)
- NUM_EP, 4: number of endpoints with a tracked data toggle; EP_W = max(1, $clog2(NUM_EP))
- EOP_BITS, 3: EOP duration in bit strobes
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- bit_stb  in  1  one-cycle pulse per USB bit period
- tx_start  in  1  data-packet request; sampled only in IDLE
- tx_ep  in  EP_W  endpoint of the data packet
- tx_len  in  LEN_W  payload byte count, 0..MAX_PAYLOAD
- tx_pid1  in  1  DATA1 select; used only when USB_TX_TOGGLE_EN is undefined
- hs_req  in  1  handshake request; sampled only in IDLE
- hs_type  in  2  0=ACK, 1=NAK, 2/3=STALL
- ack_rcvd  in  1  host ACK received for ack_ep; flips that endpoint's toggle
- ack_ep  in  EP_W  endpoint for ack_rcvd
- fifo_empty  in  1  TX FIFO empty; the FIFO is show-ahead
- fifo_pop  out  1  pop one payload byte
- load  out  1  shifter parallel-load strobe
- load_sel  out  3  0=SYNC, 1=PID, 2=DATA, 3=CRC1, 4=CRC2
- pid_byte  out  8  {~pid, pid}, valid while load_sel=PID
- shift_en  out  1  bit_stb gated to the SYNC/PID/DATA/CRC states
- eop  out  1  high for every cycle of the EOP state
- busy  out  1  high from the cycle after acceptance until after the tx_done cycle
- tx_done  out  1  one-cycle completion pulse
- underrun  out  1  one-cycle pulse when the FIFO is empty at a payload byte load

## Operation
- States: IDLE, SYNC, PID, DATA, CRC1, CRC2, EOP, DONE.
- Registers: field bit counter (0..7), remaining-byte counter (LEN_W), kind (data/handshake), latched ep, latched len, latched hs_type.
- Acceptance in IDLE:
  - hs_req has priority over tx_start when both are high in the same cycle; the data request is not queued.
  - Requests arriving while busy are ignored; requesters hold their request until busy is seen.
- Field loads:
  - On entry to each field state, load pulses for one cycle with the matching load_sel and clears the bit counter.
  - After the 8th bit_stb of the field, the FSM advances to the next field.
- Data packet sequence: SYNC -> PID -> DATA × tx_len -> CRC1 -> CRC2 -> EOP -> DONE.
  - tx_len=0 goes PID -> CRC1 directly, with no pop.
  - In DATA, each byte load pulses fifo_pop in the same cycle as load.
  - The remaining-byte counter decrements on each byte load.
  - After the 8th bit of the last byte, the FSM moves to CRC1.
- Handshake sequence: SYNC -> PID -> EOP -> DONE.
- PID bytes: ACK 8'hD2, NAK 8'h5A, STALL 8'h1E, DATA0 8'hC3, DATA1 8'h4B.
- Underrun: if fifo_empty is high when a DATA byte load is due:
  - no load and no pop occur;
  - underrun pulses;
  - the FSM goes to EOP, then DONE with tx_done.
- EOP: eop is held for EOP_BITS bit_stb, then DONE for one cycle (tx_done=1), then IDLE.
- ack_rcvd is processed in any state. If it targets the endpoint currently transmitting, the already-loaded PID is unaffected.
- tx_len above MAX_PAYLOAD is clamped to MAX_PAYLOAD at acceptance.

## Timing
- Reset: state=IDLE, all counters 0, all toggles DATA0. Every output is 0, including pid_byte=8'h00.
- Reset mid-packet aborts immediately, with no EOP and no tx_done.
- Latency: request sampled at edge N, busy=1 and SYNC load at cycle N+1.
- Packet durations in bit_stb:
  - data packet: 8·(4+tx_len)+EOP_BITS;
  - handshake: 16+EOP_BITS.
- bit_stb coinciding with a load cycle is counted as bit 0 of the new field.
- All outputs are registered or decoded from the state register only. There is no combinational path from inputs to outputs except shift_en = bit_stb & field state.

## Configuration
- USB_TX_TOGGLE_EN defined:
  - an NUM_EP-entry toggle array selects DATA0/DATA1 by the latched ep;
  - ack_rcvd flips toggle[ack_ep];
  - tx_pid1 is ignored.
- USB_TX_TOGGLE_EN undefined:
  - no toggle array;
  - PID = tx_pid1 ? DATA1 : DATA0, latched at acceptance;
  - ack_rcvd and ack_ep are unused.

## Structure
- Package usb_tx_pkg: state enum, load_sel enum, the PID constants, and the hs_type encoding.
- One sub-module, usb_tx_bitcnt: the field bit counter plus the remaining-byte counter, with last-bit and last-byte flags.

## Test plan
- Handshake: hs_req, hs_type=0 -> SYNC load, then PID load with pid_byte=8'hD2, eop for 3 strobes, tx_done; 19 bit_stb total.
- Data packet: tx_start, ep=1, len=3, FIFO holding 3 bytes -> pid_byte=8'hC3, exactly 3 pops coincident with DATA loads, CRC1/CRC2 loads, tx_done after 59 bit_stb.
- Zero-length packet: len=0 -> no fifo_pop, PID load directly followed by CRC1 load; 35 bit_stb.
- Underrun: len=4, FIFO empties after 2 bytes -> underrun pulse at the 3rd byte load slot, no 3rd pop, eop, tx_done.
- Toggle (macro on): ack_rcvd for ep=1, then a packet to ep1 -> 8'h4B, a packet to ep0 -> 8'hC3. Macro off: tx_pid1=1 -> 8'h4B.
- Collision and reset:
  - hs_req and tx_start in the same cycle -> handshake sent, data request dropped.
  - rst asserted mid-DATA -> all outputs 0 immediately, next data packet uses DATA0.
